control_unit: RTL

//  Hardwired sequencer for the 8-bit datapath. Fetches a 16-bit instruction as two byte reads into IR (low, then high).

---
 rtl/control_unit_pkg.sv | 107 ++++++++++
 rtl/control_unit_if.sv | 40 ++++
 rtl/control_unit_decoder.sv | 94 +++++++++
 rtl/control_unit.sv | 100 ++++++++++
 4 files changed

// File: rtl/control_unit_pkg.sv
// Shared types and encodings for the hardwired control unit: FSM states,
// opcodes, ALU/register-file function codes, mux selects and the control word.
package control_unit_pkg;

  typedef enum logic [2:0] {
    ST_CLR,
    ST_FETCH_L,
    ST_FETCH_H,
    ST_EXEC,
    ST_EXEC2,
    ST_HALT
  } cu_state_e;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDI = 4'h1,
    OP_LD  = 4'h2,
    OP_ST  = 4'h3,
    OP_MOV = 4'h4,
    OP_ADD = 4'h5,
    OP_SUB = 4'h6,
    OP_AND = 4'h7,
    OP_OR  = 4'h8,
    OP_XOR = 4'h9,
    OP_LSL = 4'hA,
    OP_LSR = 4'hB,
    OP_BRA = 4'hC,
    OP_BEQ = 4'hD,
    OP_BNE = 4'hE,
    OP_HLT = 4'hF
  } opcode_e;

  localparam logic [3:0] ALU_PASS_A = 4'b0000;
  localparam logic [3:0] ALU_ADD    = 4'b0100;
  localparam logic [3:0] ALU_SUB    = 4'b0101;
  localparam logic [3:0] ALU_AND    = 4'b0111;
  localparam logic [3:0] ALU_OR     = 4'b1000;
  localparam logic [3:0] ALU_XOR    = 4'b1010;
  localparam logic [3:0] ALU_LSL    = 4'b1011;
  localparam logic [3:0] ALU_LSR    = 4'b1100;

  localparam logic [1:0] FS_CLEAR = 2'b00;
  localparam logic [1:0] FS_LOAD  = 2'b01;
  localparam logic [1:0] FS_INC   = 2'b11;

  localparam logic [1:0] MUX_ALU = 2'b00;
  localparam logic [1:0] MUX_MEM = 2'b01;
  localparam logic [1:0] MUX_IRL = 2'b10;

  localparam logic [1:0] OUTB_AR = 2'b00;
  localparam logic [1:0] OUTB_PC = 2'b11;

  localparam logic [3:0] ARF_PC  = 4'b0001;
  localparam logic [3:0] ARF_AR  = 4'b1000;
  localparam logic [3:0] ARF_ALL = 4'b1111;
  localparam logic [3:0] RF_ALL  = 4'b1111;

  typedef struct packed {
    logic [1:0] outasel;
    logic [1:0] outbsel;
    logic [1:0] funsel_arf;
    logic [1:0] funsel_rf;
    logic [1:0] funsel_ir;
    logic [3:0] funsel_alu;
    logic [3:0] regsel_arf;
    logic [3:0] regsel_rf;
    logic [3:0] rf_tsel;
    logic [2:0] rf_o1sel;
    logic [2:0] rf_o2sel;
    logic [1:0] mux_sel_a;
    logic [1:0] mux_sel_b;
    logic       mux_sel_c;
    logic       wr_mem;
    logic       cs_mem;
    logic       ir_enable;
    logic       ir_lh;
  } ctrl_word_t;

  localparam ctrl_word_t CW_IDLE = '{cs_mem: 1'b1, default: '0};

  // Register code 00 is R1, which sits in the MSB of the RF regsel.
  function automatic logic [3:0] rf_onehot(input logic [1:0] code);
    return 4'b1000 >> code;
  endfunction

  function automatic logic [2:0] rf_osel(input logic [1:0] code);
    return {1'b1, code};
  endfunction

  function automatic logic is_alu_op(input opcode_e op);
    return (op >= OP_MOV) && (op <= OP_LSR);
  endfunction

  function automatic logic [3:0] alu_funsel(input opcode_e op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_XOR:  return ALU_XOR;
      OP_LSL:  return ALU_LSL;
      OP_LSR:  return ALU_LSR;
      default: return ALU_PASS_A;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control-unit <-> datapath bundle: instruction/flag inputs and the full control word.
interface control_unit_if;

  logic [15:0] ir_in;
  logic [3:0]  flags_in;
  logic [1:0]  outasel;
  logic [1:0]  outbsel;
  logic [1:0]  funsel_arf;
  logic [1:0]  funsel_rf;
  logic [1:0]  funsel_IR;
  logic [3:0]  funsel_alu;
  logic [3:0]  regsel_arf;
  logic [3:0]  regsel_rf;
  logic [3:0]  rf_tsel;
  logic [2:0]  rf_o1sel;
  logic [2:0]  rf_o2sel;
  logic [1:0]  MUXSelA;
  logic [1:0]  MUXSelB;
  logic        MUXSelC;
  logic        wrMEM;
  logic        csMEM;
  logic        IR_enable;
  logic        IR_lh;
  logic        halted;

  modport master (
    input  ir_in, flags_in,
    output outasel, outbsel, funsel_arf, funsel_rf, funsel_IR, funsel_alu,
           regsel_arf, regsel_rf, rf_tsel, rf_o1sel, rf_o2sel,
           MUXSelA, MUXSelB, MUXSelC, wrMEM, csMEM, IR_enable, IR_lh, halted
  );

  modport slave (
    output ir_in, flags_in,
    input  outasel, outbsel, funsel_arf, funsel_rf, funsel_IR, funsel_alu,
           regsel_arf, regsel_rf, rf_tsel, rf_o1sel, rf_o2sel,
           MUXSelA, MUXSelB, MUXSelC, wrMEM, csMEM, IR_enable, IR_lh, halted
  );

endinterface

// File: rtl/control_unit_decoder.sv
// Combinational control-word decode from (state, IR[15:8], latched Z).
module control_unit_decoder
  import control_unit_pkg::*;
(
  input  cu_state_e  state,
  input  logic [7:0] ir_hi,
  input  logic       z,
  output ctrl_word_t cw
);

  opcode_e    op;
  logic [1:0] rd;
  logic [1:0] rs;
  logic       take_branch;

  assign op = opcode_e'(ir_hi[7:4]);
  assign rd = ir_hi[3:2];
  assign rs = ir_hi[1:0];
  assign take_branch = (op == OP_BRA) || (op == OP_BEQ && z) || (op == OP_BNE && !z);

  always_comb begin
    cw = CW_IDLE;
    case (state)
      ST_CLR: begin
        cw.regsel_arf = ARF_ALL;
        cw.regsel_rf  = RF_ALL;
        cw.rf_tsel    = RF_ALL;
        cw.funsel_arf = FS_CLEAR;
        cw.funsel_rf  = FS_CLEAR;
        cw.ir_enable  = 1'b1;
        cw.funsel_ir  = FS_CLEAR;
      end
      ST_FETCH_L, ST_FETCH_H: begin
        cw.outbsel    = OUTB_PC;
        cw.cs_mem     = 1'b0;
        cw.ir_enable  = 1'b1;
        cw.funsel_ir  = FS_LOAD;
        cw.ir_lh      = (state == ST_FETCH_H);
        cw.regsel_arf = ARF_PC;
        cw.funsel_arf = FS_INC;
      end
      ST_EXEC: begin
        case (op)
          OP_LDI: begin
            cw.mux_sel_a = MUX_IRL;
            cw.regsel_rf = rf_onehot(rd);
            cw.funsel_rf = FS_LOAD;
          end
          OP_LD, OP_ST: begin
            cw.mux_sel_b  = MUX_IRL;
            cw.regsel_arf = ARF_AR;
            cw.funsel_arf = FS_LOAD;
          end
          OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LSL, OP_LSR: begin
            cw.rf_o1sel   = rf_osel((op == OP_MOV) ? rs : rd);
            cw.rf_o2sel   = rf_osel(rs);
            cw.mux_sel_c  = 1'b0;
            cw.funsel_alu = alu_funsel(op);
            cw.mux_sel_a  = MUX_ALU;
            cw.regsel_rf  = rf_onehot(rd);
            cw.funsel_rf  = FS_LOAD;
          end
          OP_BRA, OP_BEQ, OP_BNE: begin
            if (take_branch) begin
              cw.mux_sel_b  = MUX_IRL;
              cw.regsel_arf = ARF_PC;
              cw.funsel_arf = FS_LOAD;
            end
          end
          default: ;
        endcase
      end
      ST_EXEC2: begin
        // IR still holds the LD/ST that entered EXEC2, so the opcode is stable here.
        if (op == OP_LD) begin
          cw.outbsel   = OUTB_AR;
          cw.cs_mem    = 1'b0;
          cw.mux_sel_a = MUX_MEM;
          cw.regsel_rf = rf_onehot(rd);
          cw.funsel_rf = FS_LOAD;
        end else if (op == OP_ST) begin
          cw.outbsel    = OUTB_AR;
          cw.cs_mem     = 1'b0;
          cw.wr_mem     = 1'b1;
          cw.rf_o1sel   = rf_osel(rs);
          cw.mux_sel_c  = 1'b0;
          cw.funsel_alu = ALU_PASS_A;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired sequencer top: state register, latched Z flag, optional step gate.
// Optional feature macro: CU_SINGLE_STEP_EN (adds the step input, gating FETCH_L).
module control_unit
  import control_unit_pkg::*;
#(
  parameter int unsigned BOOT_CLEAR = 1
) (
  input logic clk,
  input logic rst_n,
`ifdef CU_SINGLE_STEP_EN
  input logic step,
`endif
  control_unit_if.master bus
);

  localparam cu_state_e RESET_STATE = (BOOT_CLEAR != 0) ? ST_CLR : ST_FETCH_L;

  cu_state_e  state_q, state_d;
  logic       z_q, z_d;
  opcode_e    op;
  logic       step_ok;
  logic       fetch_hold;
  ctrl_word_t dec_cw;
  ctrl_word_t cw;
  logic       unused_bits;

  assign op          = opcode_e'(bus.ir_in[15:12]);
  assign unused_bits = ^{bus.ir_in[7:0], bus.flags_in[2:0]};

`ifdef CU_SINGLE_STEP_EN
  assign step_ok = step;
`else
  assign step_ok = 1'b1;
`endif

  assign fetch_hold = (state_q == ST_FETCH_L) && !step_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RESET_STATE;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      z_q     <= z_d;
    end
  end

  always_comb begin
    state_d = state_q;
    z_d     = z_q;
    case (state_q)
      ST_CLR:     state_d = ST_FETCH_L;
      ST_FETCH_L: if (step_ok) state_d = ST_FETCH_H;
      ST_FETCH_H: state_d = ST_EXEC;
      ST_EXEC: begin
        if (is_alu_op(op)) z_d = bus.flags_in[3];
        if (op == OP_LD || op == OP_ST) state_d = ST_EXEC2;
        else if (op == OP_HLT)          state_d = ST_HALT;
        else                            state_d = ST_FETCH_L;
      end
      ST_EXEC2:   state_d = ST_FETCH_L;
      ST_HALT:    state_d = ST_HALT;
      default:    state_d = RESET_STATE;
    endcase
  end

  control_unit_decoder u_decoder (
    .state (state_q),
    .ir_hi (bus.ir_in[15:8]),
    .z     (z_q),
    .cw    (dec_cw)
  );

  // Reset low forces the idle word at once, even though the reset state may be CLR.
  always_comb begin
    cw = dec_cw;
    if (!rst_n || fetch_hold) cw = CW_IDLE;
  end

  assign bus.outasel    = cw.outasel;
  assign bus.outbsel    = cw.outbsel;
  assign bus.funsel_arf = cw.funsel_arf;
  assign bus.funsel_rf  = cw.funsel_rf;
  assign bus.funsel_IR  = cw.funsel_ir;
  assign bus.funsel_alu = cw.funsel_alu;
  assign bus.regsel_arf = cw.regsel_arf;
  assign bus.regsel_rf  = cw.regsel_rf;
  assign bus.rf_tsel    = cw.rf_tsel;
  assign bus.rf_o1sel   = cw.rf_o1sel;
  assign bus.rf_o2sel   = cw.rf_o2sel;
  assign bus.MUXSelA    = cw.mux_sel_a;
  assign bus.MUXSelB    = cw.mux_sel_b;
  assign bus.MUXSelC    = cw.mux_sel_c;
  assign bus.wrMEM      = cw.wr_mem;
  assign bus.csMEM      = cw.cs_mem;
  assign bus.IR_enable  = cw.ir_enable;
  assign bus.IR_lh      = cw.ir_lh;
  assign bus.halted     = (state_q == ST_HALT) && rst_n;

endmodule
